// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: byte/halfword/word loads and stores against a
// word-organised RAM, with a fixed multi-cycle latency and a stall to the hazard logic.
module dmem_access_unit #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALURESMin,
  input  logic [31:0] WDATAin,
  input  logic        MEMRD,
  input  logic        MEMWR,
  input  logic [2:0]  FUNCT3,
  output logic [31:0] RDATAout,
  output logic        DONEout,
  output logic        STALLout,
  output logic        FAULTout,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 2;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          capture;
  logic          acc_go;
  logic          stall;

  logic [IW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_f3;
  logic          lat_wr;

  logic [IW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_f3;
  logic          acc_wr;
  logic [AW-1:0] acc_idx;

  logic          req;
  logic          req_fault;
  logic          req_ok;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_word;
  logic [3:0]    lane_we;
  logic [31:0]   wr_lanes;
  logic [31:0]   wr_merged;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  // Address bits above the RAM index are deliberately dropped so addresses wrap.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^ALURESMin[31:IW];

  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] a,
                                        input logic wr);
    logic legal;
    logic misal;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~wr;
      default:                legal = 1'b0;
    endcase
    misal = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return ~legal | misal;
  endfunction

  // A store wins when MEMRD and MEMWR are both raised.
  assign req       = MEMRD | MEMWR;
  assign req_fault = access_fault(FUNCT3, ALURESMin[1:0], MEMWR);
  assign req_ok    = req & ~req_fault;

  // STALLout is the only handshake: while it is high the upstream registers hold
  // ALURESMin/WDATAin/FUNCT3/MEMRD/MEMWR; the request is consumed on the edge
  // leaving DONE (or the edge of a faulting request), where STALLout is low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    acc_go    = 1'b0;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          stall   = 1'b1;
          capture = 1'b1;
          if (LAT == 1) begin
            acc_go    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt_nxt == 4'd0) begin
          acc_go    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // In IDLE the access (LAT=1 only) uses the live inputs; otherwise the latched copies.
  always_comb begin
    if (state == S_IDLE) begin
      acc_addr  = ALURESMin[IW-1:0];
      acc_wdata = WDATAin;
      acc_f3    = FUNCT3;
      acc_wr    = MEMWR;
    end else begin
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_f3    = lat_f3;
      acc_wr    = lat_wr;
    end
  end

  assign acc_idx  = acc_addr[IW-1:2];
  assign ram_word = mem[acc_idx];

  always_comb begin
    lane_we  = 4'b1111;
    wr_lanes = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        lane_we  = 4'b0001 << acc_addr[1:0];
        wr_lanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        lane_we  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        lane_we  = 4'b1111;
        wr_lanes = acc_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_merged[i*8 +: 8] = lane_we[i] ? wr_lanes[i*8 +: 8] : ram_word[i*8 +: 8];
    end
  end

  assign byte_sel = ram_word[{acc_addr[1:0], 3'b000} +: 8];
  assign half_sel = acc_addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    case (acc_f3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = ram_word;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_f3    <= 3'd0;
      lat_wr    <= 1'b0;
      RDATAout  <= 32'd0;
      FAULTout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      FAULTout <= (state == S_IDLE) && req && req_fault;
      if (capture) begin
        lat_addr  <= ALURESMin[IW-1:0];
        lat_wdata <= WDATAin;
        lat_f3    <= FUNCT3;
        lat_wr    <= MEMWR;
      end
      if (acc_go && !acc_wr) begin
        RDATAout <= load_data;
      end
    end
  end

  // RAM contents survive reset; an aborted access never reaches here because
  // reset forces the FSM to IDLE before the next edge.
  always_ff @(negedge clk) begin
    if (acc_go && acc_wr) begin
      mem[acc_idx] <= wr_merged;
    end
  end

  assign DONEout   = (state == S_DONE);
  assign STALLout  = stall;
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed load/store vectors checked against a
// byte-array memory model and a per-cycle timeline of expected outputs.
module tb_dmem_access_unit;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int NB    = DEPTH * 4;
  localparam int MAXC  = 1024;

  logic        clk;
  logic        reset;
  logic [31:0] ALURESMin;
  logic [31:0] WDATAin;
  logic        MEMRD;
  logic        MEMWR;
  logic [2:0]  FUNCT3;
  logic [31:0] RDATAout;
  logic        DONEout;
  logic        STALLout;
  logic        FAULTout;
  logic [1:0]  state_dbg;

  dmem_access_unit #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .ALURESMin(ALURESMin),
    .WDATAin(WDATAin),
    .MEMRD(MEMRD),
    .MEMWR(MEMWR),
    .FUNCT3(FUNCT3),
    .RDATAout(RDATAout),
    .DONEout(DONEout),
    .STALLout(STALLout),
    .FAULTout(FAULTout),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k starts at the k-th falling edge (the active edge).
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  logic [7:0]  mbytes [NB];
  bit          exp_stall [MAXC];
  bit          exp_done  [MAXC];
  bit          exp_fault [MAXC];
  logic [31:0] exp_q[$];
  int          exp_cyc[$];
  logic [31:0] cur_rdata = 32'd0;
  bit          chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] addr,
                                     input bit wr);
    int unsigned sz = acc_size(f3);
    if (sz == 0) return 1'b1;
    if (wr && f3[2]) return 1'b1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = acc_size(f3);
    logic [31:0] v = 32'd0;
    logic [31:0] mask;
    for (int i = 0; i < int'(sz); i++) begin
      v = v | (32'(mbytes[(addr + 32'(i)) % NB]) << (8 * i));
    end
    if (sz < 4 && !f3[2] && v[8*sz-1]) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v | ~mask;
    end
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int unsigned sz = acc_size(f3);
    for (int i = 0; i < int'(sz); i++) begin
      mbytes[(addr + 32'(i)) % NB] = wdata[8*i +: 8];
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    if (chk_en) begin
      while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
        cur_rdata = exp_q.pop_front();
        void'(exp_cyc.pop_front());
      end
      check("stall", 32'(STALLout), 32'(exp_stall[cyc]));
      check("done",  32'(DONEout),  32'(exp_done[cyc]));
      check("fault", 32'(FAULTout), 32'(exp_fault[cyc]));
      check("rdata", RDATAout, cur_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      MEMRD = 1'b0;
      MEMWR = 1'b0;
    end
  endtask

  // Presents one request; for a good access it returns in the DONE cycle with the
  // request still held, so the next call issues back-to-back.
  task automatic issue(input string nm, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit has_lit,
                       input logic [31:0] lit);
    int c;
    logic [31:0] v;
    @(negedge clk); #1;
    c = cyc;
    MEMRD = rd; MEMWR = wr; FUNCT3 = f3; ALURESMin = addr; WDATAin = wdata;
    if (model_fault(f3, addr, wr)) begin
      exp_fault[c+1] = 1'b1;
    end else begin
      for (int k = 0; k < LAT; k++) exp_stall[c+k] = 1'b1;
      exp_done[c+LAT] = 1'b1;
      if (!wr) begin
        v = model_load(f3, addr);
        exp_q.push_back(v);
        exp_cyc.push_back(c + LAT);
      end
      repeat (LAT) @(negedge clk);
      #3;
      if (has_lit) check(nm, RDATAout, lit);
      if (wr) model_store(f3, addr, wdata);
    end
  endtask

  // Store interrupted by reset while BUSY: it must leave no trace in the RAM.
  task automatic reset_mid_busy();
    int c;
    @(negedge clk); #1;
    c = cyc;
    MEMRD = 1'b0; MEMWR = 1'b1; FUNCT3 = 3'b010; ALURESMin = 32'h30; WDATAin = 32'h12345678;
    exp_stall[c] = 1'b1;
    @(negedge clk); #2;
    reset = 1'b1;
    MEMWR = 1'b0;
    exp_q.push_back(32'd0);
    exp_cyc.push_back(c + 1);
    #1;
    check("rst_rdata", RDATAout, 32'd0);
    check("rst_done",  32'(DONEout),  32'd0);
    check("rst_fault", 32'(FAULTout), 32'd0);
    check("rst_stall", 32'(STALLout), 32'd0);
    @(negedge clk); #2;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NB; i++) mbytes[i] = 8'h00;
    reset = 1'b1;
    MEMRD = 1'b0; MEMWR = 1'b0; FUNCT3 = 3'b000; ALURESMin = 32'd0; WDATAin = 32'd0;
    #2;
    check("init_rdata", RDATAout, 32'd0);
    check("init_done",  32'(DONEout),  32'd0);
    check("init_fault", 32'(FAULTout), 32'd0);
    check("init_stall", 32'(STALLout), 32'd0);
    @(negedge clk); #3;
    reset  = 1'b0;
    chk_en = 1'b1;

    issue("sw_10",   1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h00000000);
    issue("lw_10",   1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF);
    issue("sb_11",   1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF7F, 1'b1, 32'hDEADBEEF);
    issue("lw_10b",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 32'hDEAD7FEF);
    idle($urandom_range(0, 2));
    issue("lb_13",   1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        1'b1, 32'hFFFFFFDE);
    issue("lbu_13",  1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        1'b1, 32'h000000DE);
    issue("lh_12",   1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        1'b1, 32'hFFFFDEAD);
    issue("lhu_12",  1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        1'b1, 32'h0000DEAD);
    issue("sh_20",   1'b0, 1'b1, 3'b001, 32'h20, 32'h00008001, 1'b1, 32'h0000DEAD);
    issue("lh_20",   1'b1, 1'b0, 3'b001, 32'h20, 32'h0,        1'b1, 32'hFFFF8001);
    idle($urandom_range(0, 2));
    issue("lw_12f",  1'b1, 1'b0, 3'b010, 32'h12, 32'h0,        1'b0, 32'h0);
    issue("ld_011f", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        1'b0, 32'h0);
    issue("sh_21f",  1'b0, 1'b1, 3'b001, 32'h21, 32'h0000FFFF, 1'b0, 32'h0);
    issue("sbu_f",   1'b0, 1'b1, 3'b100, 32'h10, 32'h000000AA, 1'b0, 32'h0);
    issue("lw_10c",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 32'hDEAD7FEF);
    issue("sw_400",  1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 1'b1, 32'hDEAD7FEF);
    issue("lw_000",  1'b1, 1'b0, 3'b010, 32'h000, 32'h0,       1'b1, 32'hCAFEF00D);
    idle($urandom_range(0, 2));
    issue("rdwr_44", 1'b1, 1'b1, 3'b010, 32'h44, 32'h11223344, 1'b1, 32'hCAFEF00D);
    issue("lw_44",   1'b1, 1'b0, 3'b010, 32'h44, 32'h0,        1'b1, 32'h11223344);
    issue("sb_46",   1'b0, 1'b1, 3'b000, 32'h46, 32'h123456A5, 1'b1, 32'h11223344);
    issue("lw_44b",  1'b1, 1'b0, 3'b010, 32'h44, 32'h0,        1'b1, 32'h11A53344);
    issue("sh_46",   1'b0, 1'b1, 3'b001, 32'h46, 32'hAAAABEEF, 1'b1, 32'h11A53344);
    issue("lw_44c",  1'b1, 1'b0, 3'b010, 32'h44, 32'h0,        1'b1, 32'hBEEF3344);
    issue("lhu_46",  1'b1, 1'b0, 3'b101, 32'h46, 32'h0,        1'b1, 32'h0000BEEF);
    issue("lb_44",   1'b1, 1'b0, 3'b000, 32'h44, 32'h0,        1'b1, 32'h00000044);

    reset_mid_busy();
    issue("lw_30",   1'b1, 1'b0, 3'b010, 32'h30, 32'h0,        1'b1, 32'h00000000);
    issue("lw_10d",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 32'hDEAD7FEF);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage data-memory controller, directly downstream of the MEM-stage ALU-result register.
- Takes the registered ALU result as the byte address and performs loads and stores of byte, halfword or word size against an internal word-organised RAM.
- Models a fixed multi-cycle access latency, using a small FSM and a stall output to the hazard logic.
- Produces the extended load data for the MEM/WB register.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM (power of two).
- LAT, 2, access latency in cycles from request acceptance to completion (1..15).

Ports:
- clk  input  1  clock; all sequential elements update on the falling edge, matching the pipeline registers.
- reset  input  1  asynchronous, active-high reset.
- ALURESMin  input  32  byte address, taken from the MEM-stage ALU-result register.
- WDATAin  input  32  store data (rs2 value).
- MEMRD  input  1  load request.
- MEMWR  input  1  store request.
- FUNCT3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RDATAout  output  32  extended load data.
- DONEout  output  1  one-cycle pulse when an access completes.
- STALLout  output  1  freezes the upstream pipeline registers.
- FAULTout  output  1  one-cycle pulse on a misaligned access or an illegal FUNCT3.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - FSM returns to IDLE and the latency counter is cleared.
  - RDATAout=0, DONEout=0, FAULTout=0.
  - RAM contents are not cleared. RAM is zero-initialised at time 0 only.
- A request is valid when MEMRD or MEMWR is high. If both are high, the access is a store.
- Alignment rules:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - FUNCT3 values 011, 110 and 111 are illegal for loads. For stores, only 000, 001 and 010 are legal.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, with a valid, aligned, legal request: latch address, data, FUNCT3 and type. Load the counter with LAT-1 and go to BUSY. If LAT=1, go directly to DONE.
  - IDLE, with a faulting request: no RAM access, FAULTout=1 for the next cycle, stay in IDLE, no stall.
  - BUSY: decrement the counter. At 0, perform the RAM access using the latched values and go to DONE.
  - DONE: DONEout=1 for exactly this cycle. On a load, RDATAout is updated on entry to DONE. Go to IDLE unconditionally; request inputs are ignored in DONE.
- STALLout is combinational: it is 1 when (IDLE and a valid non-faulting request) or in BUSY, and 0 in DONE.
  - The pipeline advances on the edge that leaves DONE, so each request is serviced exactly once.
- Inputs change only while STALLout=0. Inputs that change while BUSY are ignored because latched copies are used.
- Store lane enables:
  - B writes lane addr[1:0], using WDATAin[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1}, using WDATAin[15:0].
  - W writes all four lanes.
  - Unwritten lanes are preserved.
- Load extraction:
  - B sign-extends the selected byte; BU zero-extends it.
  - H sign-extends the selected halfword; HU zero-extends it.
  - W passes the word through.
- RDATAout holds its value until the next load completes. Stores do not change it.
- Lane mapping is little-endian: lane 0 = bits 7:0.
- Reset asserted in BUSY aborts the access: no RAM write occurs and no DONE pulse is issued.
- Latency from the request edge to the DONEout pulse is LAT cycles. Back-to-back requests are spaced LAT+1 cycles apart.

Test Plan:
- LAT=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> STALLout high 2 cycles each; DONEout pulses; RDATAout=0xDEADBEEF.
- After the word above: SB 0x11 data 0x7F, then LW 0x10 -> RDATAout=0xDEAD7FEF. LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE.
- LH 0x12 -> 0xFFFFDEAD. LHU 0x12 -> 0x0000DEAD.
- SH 0x20 data 0x8001, then LH 0x20 -> 0xFFFF8001.
- LW 0x12 (misaligned) and FUNCT3=011 load -> FAULTout pulses 1 cycle; STALLout stays 0; RAM and RDATAout unchanged; no DONEout.
- SW to addr 0x400 with DEPTH=256 -> wraps; LW 0x000 returns the stored data.
- Reset asserted mid-BUSY on SW 0x30 data 0x12345678 -> outputs go to 0 immediately; FSM returns to IDLE; LW 0x30 returns the prior contents (0x00000000).
